// File: rtl/hh_pkg.sv
// Shared types and constants for the Hodgkin-Huxley gate update scheduler.
package hh_pkg;

   localparam logic [1:0] GATE_M = 2'd0;
   localparam logic [1:0] GATE_H = 2'd1;
   localparam logic [1:0] GATE_N = 2'd2;

   localparam logic signed [15:0] GATE_SCALE = 16'sd1000;

   localparam logic signed [15:0] M_REST = 16'sd53;
   localparam logic signed [15:0] H_REST = 16'sd596;
   localparam logic signed [15:0] N_REST = 16'sd318;

   typedef enum logic [2:0] {IDLE, REQ_M, REQ_H, REQ_N, DONE} state_e;

endpackage

// File: rtl/gate_update_scheduler_if.sv
// Step control, published gate values and the shared-datapath handshake.
// err exists only when GATE_TIMEOUT_EN is defined.
interface gate_update_scheduler_if;

   logic               start;
   logic signed [15:0] v;
   logic        [15:0] dt;
   logic               busy;
   logic               step_done;
   logic signed [15:0] m_out, h_out, n_out;
   logic        [15:0] step_count;
   logic               dp_req;
   logic        [1:0]  dp_sel;
   logic signed [15:0] dp_v;
   logic        [15:0] dp_dt;
   logic signed [15:0] dp_x;
   logic               dp_ack;
   logic signed [15:0] dp_x_next;

`ifdef GATE_TIMEOUT_EN
   logic               err;

   modport master (
      output start, v, dt, dp_ack, dp_x_next,
      input  busy, step_done, m_out, h_out, n_out, step_count,
             dp_req, dp_sel, dp_v, dp_dt, dp_x, err
   );
   modport slave (
      input  start, v, dt, dp_ack, dp_x_next,
      output busy, step_done, m_out, h_out, n_out, step_count,
             dp_req, dp_sel, dp_v, dp_dt, dp_x, err
   );
`else
   modport master (
      output start, v, dt, dp_ack, dp_x_next,
      input  busy, step_done, m_out, h_out, n_out, step_count,
             dp_req, dp_sel, dp_v, dp_dt, dp_x
   );
   modport slave (
      input  start, v, dt, dp_ack, dp_x_next,
      output busy, step_done, m_out, h_out, n_out, step_count,
             dp_req, dp_sel, dp_v, dp_dt, dp_x
   );
`endif

endinterface

// File: rtl/gate_clamp.sv
// Combinational clamp of a signed gate value into 0..GATE_SCALE.
module gate_clamp
   import hh_pkg::*;
(
   input  logic signed [15:0] x_i,
   output logic signed [15:0] y_o
);

   always_comb begin
      y_o = x_i;
      if (x_i < 16'sd0)
         y_o = 16'sd0;
      else if (x_i > GATE_SCALE)
         y_o = GATE_SCALE;
   end

endmodule

// File: rtl/gate_update_scheduler.sv
// Sequences m/h/n updates through a shared datapath and publishes all three at once.
// Optional watchdog on each datapath transaction: define GATE_TIMEOUT_EN.
module gate_update_scheduler
   import hh_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic                   clk,
   input logic                   reset,
   gate_update_scheduler_if.slave bus
);

   state_e             state_q, state_d;
   logic signed [15:0] v_q;
   logic        [15:0] dt_q;
   logic signed [15:0] shadow_q [3];
   logic signed [15:0] gate_q   [3];
   logic        [15:0] step_cnt_q;
   logic               step_done_q;
   logic               dp_req;
   logic               xfer;
   logic               tmo_hit;
   logic        [1:0]  sel;
   logic signed [15:0] x_clamped;

   assign dp_req = (state_q == REQ_M) || (state_q == REQ_H) || (state_q == REQ_N);
   assign xfer   = dp_req && bus.dp_ack;

   always_comb begin
      state_d = state_q;
      sel     = GATE_M;
      case (state_q)
         IDLE:    if (bus.start) state_d = REQ_M;
         REQ_M:   begin sel = GATE_M; if (bus.dp_ack) state_d = REQ_H; end
         REQ_H:   begin sel = GATE_H; if (bus.dp_ack) state_d = REQ_N; end
         REQ_N:   begin sel = GATE_N; if (bus.dp_ack) state_d = DONE;  end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (tmo_hit) state_d = IDLE;
   end

   gate_clamp u_clamp (
      .x_i (bus.dp_x_next),
      .y_o (x_clamped)
   );

   // Shadows collect results mid-step; gate_q only changes on the DONE edge,
   // so dp_x always reflects the last fully published step.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         v_q         <= '0;
         dt_q        <= '0;
         shadow_q    <= '{M_REST, H_REST, N_REST};
         gate_q      <= '{M_REST, H_REST, N_REST};
         step_cnt_q  <= '0;
         step_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_done_q <= (state_q == DONE);
         if (state_q == IDLE && bus.start) begin
            v_q  <= bus.v;
            dt_q <= bus.dt;
         end
         if (xfer) shadow_q[sel] <= x_clamped;
         if (state_q == DONE) begin
            gate_q     <= shadow_q;
            step_cnt_q <= step_cnt_q + 16'd1;
         end
      end
   end

`ifdef GATE_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TMO_W-1:0] tmo_q;
   logic             err_q;

   assign tmo_hit = dp_req && !bus.dp_ack && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         tmo_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (!dp_req || bus.dp_ack) tmo_q <= '0;
         else                       tmo_q <= tmo_q + 1'b1;
         if (tmo_hit) err_q <= 1'b1;
      end
   end

   assign bus.err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
   assign tmo_hit        = 1'b0;
`endif

   assign bus.busy       = (state_q != IDLE);
   assign bus.step_done  = step_done_q;
   assign bus.m_out      = gate_q[0];
   assign bus.h_out      = gate_q[1];
   assign bus.n_out      = gate_q[2];
   assign bus.step_count = step_cnt_q;
   assign bus.dp_req     = dp_req;
   assign bus.dp_sel     = sel;
   assign bus.dp_v       = v_q;
   assign bus.dp_dt      = dt_q;
   assign bus.dp_x       = gate_q[sel];

endmodule
